// File: rtl/deser_pkg.sv
// Shared definitions for the serial word deserializer: FSM state encoding
// and the sizing helper for the bit counter.
package deser_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        DONE   = 2'd3
    } deser_state_t;

    // Width of a counter that must hold values 0 .. n-1.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/deser_bit_counter.sv
// Bit counter for the deserializer. Counts accepted bits from 0 up to N-1 and
// flags the terminal count in the same cycle the last bit is accepted.
module deser_bit_counter
    import deser_pkg::*;
#(
    parameter int N = 8,
    parameter int W = cnt_width(N)
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign tc = en && (count_q == LAST);

    // Next count: clear wins; wrap to zero on the terminal bit so the count never passes N-1.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = tc ? '0 : count_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/serial_word_deserializer.sv
// Serial-in, parallel-out word assembler. Shifts n qualified serial bits into a
// word, optionally checks one trailing even-parity bit, and presents the word
// with a one-cycle load strobe. All outputs come straight from flops.
module serial_word_deserializer
    import deser_pkg::*;
#(
    parameter int n         = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         s_en,
    input  logic         s_in,
    output logic [n-1:0] word,
    output logic         load,
    output logic         parity_err,
    output logic         busy
);

    deser_state_t state_q, state_d;
    logic [n-1:0] shreg_q, shreg_d;
    logic [n-1:0] word_q, word_d;
    logic         load_q, load_d;
    logic         perr_q, perr_d;
    logic         busy_q, busy_d;
    logic [n-1:0] shifted;
    logic         cnt_clr;
    logic         cnt_en;
    logic         cnt_tc;

    // Shift direction is fixed at elaboration time.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign shifted = {shreg_q[n-2:0], s_in};
        end else begin : g_lsb_first
            assign shifted = {s_in, shreg_q[n-1:1]};
        end
    endgenerate

    // Counter controls depend only on state and inputs, keeping tc free of feedback.
    assign cnt_clr = (state_q == IDLE) && start;
    assign cnt_en  = (state_q == SHIFT) && s_en;

    deser_bit_counter #(
        .N (n)
    ) u_bit_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .tc    (cnt_tc)
    );

    // Next-state and next-output logic; outputs are precomputed so DONE sees them registered.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        word_d  = word_q;
        perr_d  = perr_q;
        load_d  = 1'b0;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    shreg_d = '0;
                    busy_d  = 1'b1;
                end
            end
            SHIFT: begin
                if (s_en) begin
                    shreg_d = shifted;
                    if (cnt_tc) begin
                        if (PARITY_EN) begin
                            state_d = PARITY;
                        end else begin
                            state_d = DONE;
                            word_d  = shifted;
                            perr_d  = 1'b0;
                            load_d  = 1'b1;
                            busy_d  = 1'b0;
                        end
                    end
                end
            end
            PARITY: begin
                if (s_en) begin
                    state_d = DONE;
                    word_d  = shreg_q;
                    perr_d  = (^shreg_q) ^ s_in;
                    load_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            DONE: begin
                // start is deliberately ignored here; the next frame may begin in IDLE.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, shift register and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            word_q  <= '0;
            load_q  <= 1'b0;
            perr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            word_q  <= word_d;
            load_q  <= load_d;
            perr_q  <= perr_d;
            busy_q  <= busy_d;
        end
    end

    assign word       = word_q;
    assign load       = load_q;
    assign parity_err = perr_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Testbench for serial_word_deserializer. Two instances: A (MSB first, parity)
// and B (LSB first, no parity). Stimulus pushes expected words into per-DUT
// queues; a negedge monitor pops and compares whenever load is seen.
module tb_serial_word_deserializer;

    localparam int N = 8;

    typedef struct {
        logic [N-1:0] w;
        logic         pe;
        int           at;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [1:0]   start_v = '0;
    logic [1:0]   s_en_v = '0;
    logic [1:0]   s_in_v = '0;
    logic [N-1:0] word_a, word_b;
    logic         load_a, load_b, perr_a, perr_b, busy_a, busy_b;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   loads[2];
    int   last_load[2];
    logic prev_load[2];
    exp_t q0[$];
    exp_t q1[$];

    serial_word_deserializer #(.n(N), .MSB_FIRST(1'b1), .PARITY_EN(1'b1)) dut_a (
        .clk(clk), .reset(reset), .start(start_v[0]), .s_en(s_en_v[0]), .s_in(s_in_v[0]),
        .word(word_a), .load(load_a), .parity_err(perr_a), .busy(busy_a)
    );

    serial_word_deserializer #(.n(N), .MSB_FIRST(1'b0), .PARITY_EN(1'b0)) dut_b (
        .clk(clk), .reset(reset), .start(start_v[1]), .s_en(s_en_v[1]), .s_in(s_in_v[1]),
        .word(word_b), .load(load_b), .parity_err(perr_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: the i-th received bit lands at word[N-1-i] (MSB first) or word[i].
    function automatic logic [N-1:0] model_word(input logic [N-1:0] rx, input bit msb);
        logic [N-1:0] w;
        w = '0;
        for (int i = 0; i < N; i++) begin
            if (msb) w[N-1-i] = rx[i];
            else     w[i]     = rx[i];
        end
        return w;
    endfunction

    // Even parity error: total count of ones over data plus parity bit is odd.
    function automatic logic model_parity(input logic [N-1:0] rx, input logic pbit);
        int ones;
        ones = int'(pbit);
        for (int i = 0; i < N; i++) ones += int'(rx[i]);
        return (ones % 2) != 0;
    endfunction

    function automatic logic busy_of(input int k);
        return (k == 0) ? busy_a : busy_b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic mon(input int k, input logic ld, input logic [N-1:0] w, input logic pe, input logic bsy);
        exp_t e;
        bit   have;
        if (ld === 1'b1) begin
            loads[k]++;
            last_load[k] = cyc;
            check($sformatf("load_single_cycle_%0d", k), 32'(prev_load[k]), 32'd0);
            have = 1'b0;
            if (k == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            if (k == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            if (!have) begin
                checks++;
                errors++;
                $display("FAIL unexpected_load_%0d: got load with word 0x%0h, expected no load (cycle %0d)", k, w, cyc);
            end else begin
                $display("dut%0d load word=0x%0h parity_err=%0b cycle=%0d (expected word=0x%0h pe=%0b cycle=%0d)",
                         k, w, pe, cyc, e.w, e.pe, e.at);
                check($sformatf("word_%0d", k), 32'(w), 32'(e.w));
                check($sformatf("parity_err_%0d", k), 32'(pe), 32'(e.pe));
                check($sformatf("busy_at_load_%0d", k), 32'(bsy), 32'd0);
                check($sformatf("load_cycle_%0d", k), 32'(cyc), 32'(e.at));
            end
        end
        prev_load[k] = ld;
    endtask

    // Monitor: compares every load against the scoreboard, away from the rising edge.
    always @(negedge clk) begin
        mon(0, load_a, word_a, perr_a, busy_a);
        mon(1, load_b, word_b, perr_b, busy_b);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one frame on DUT k; rx[i] is the i-th bit on the wire.
    task automatic send_frame(input int k, input logic [N-1:0] rx, input logic pbit,
                              input bit do_start, input bit hold_start,
                              input int bubble_after, input int bubbles,
                              input bit rand_gaps, input bit start_noise);
        exp_t e;
        bit   par;
        int   g;
        par = (k == 0);
        if (do_start) begin
            start_v[k] = 1'b1;
            tick();
            if (!hold_start) start_v[k] = 1'b0;
            check($sformatf("busy_after_start_%0d", k), 32'(busy_of(k)), 32'd1);
        end
        for (int i = 0; i <= N; i++) begin
            if (i == N && !par) break;
            if (i == bubble_after) begin
                s_en_v[k] = 1'b0;
                repeat (bubbles) tick();
            end
            g = rand_gaps ? $urandom_range(0, 2) : 0;
            for (int j = 0; j < g; j++) begin
                s_en_v[k] = 1'b0;
                s_in_v[k] = 1'($urandom_range(0, 1));
                if (start_noise) start_v[k] = 1'($urandom_range(0, 1));
                tick();
            end
            s_en_v[k] = 1'b1;
            s_in_v[k] = (i == N) ? pbit : rx[i];
            if (start_noise) start_v[k] = 1'($urandom_range(0, 1));
            tick();
        end
        s_en_v[k] = 1'b0;
        s_in_v[k] = 1'b0;
        if (start_noise) start_v[k] = 1'b0;
        e.w  = model_word(rx, k == 0);
        e.pe = par ? model_parity(rx, pbit) : 1'b0;
        e.at = cyc;
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    initial begin
        int l0;
        int c0;
        loads     = '{0, 0};
        last_load = '{0, 0};
        prev_load = '{1'b0, 1'b0};

        // Reset, then idle with no stimulus.
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_a", {word_a, load_a, busy_a}, 32'd0);
            check("idle_b", {word_b, load_b, busy_b}, 32'd0);
        end

        // Bits 1,0,1,1,0,0,1,0 with parity 0 on A -> 0xB2, no error.
        l0 = loads[0];
        send_frame(0, 8'h4D, 1'b0, 1, 0, -1, 0, 0, 0);
        repeat (3) tick();
        check("load_count_b2", 32'(loads[0] - l0), 32'd1);
        check("word_hold_b2", 32'(word_a), 32'hB2);

        // Same frame with a bad parity bit, then a good 0x0F frame clears the flag.
        send_frame(0, 8'h4D, 1'b1, 1, 0, -1, 0, 0, 0);
        tick();
        check("perr_set", 32'(perr_a), 32'd1);
        send_frame(0, 8'hF0, 1'b0, 1, 0, -1, 0, 0, 0);
        tick();
        check("perr_cleared", 32'(perr_a), 32'd0);

        // LSB first, no parity, 3 bubble cycles after bit 4 -> 0x4D, frame 10+3 cycles.
        c0 = cyc;
        send_frame(1, 8'h4D, 1'b0, 1, 0, 4, 3, 0, 0);
        repeat (2) tick();
        check("bubble_frame_len", 32'(last_load[1] - c0 + 1), 32'd13);
        check("word_b_4d", 32'(word_b), 32'h4D);

        // Reset after 5 of 8 bits discards the frame.
        l0 = loads[0];
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_en_v[0] = 1'b1;
            s_in_v[0] = 1'b1;
            tick();
        end
        s_en_v[0] = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("word_after_reset", 32'(word_a), 32'd0);
        check("busy_after_reset", 32'(busy_a), 32'd0);
        repeat (4) tick();
        check("no_load_aborted", 32'(loads[0] - l0), 32'd0);
        send_frame(0, 8'hA5, 1'b0, 1, 0, -1, 0, 0, 0);
        repeat (2) tick();
        check("load_count_a5", 32'(loads[0] - l0), 32'd1);
        check("word_a5", 32'(word_a), 32'hA5);

        // start held high across two back-to-back frames.
        l0 = loads[0];
        send_frame(0, 8'($urandom), 1'($urandom_range(0, 1)), 1, 1, -1, 0, 0, 0);
        check("busy_low_done", 32'(busy_a), 32'd0);
        tick();
        check("busy_low_idle", 32'(busy_a), 32'd0);
        tick();
        check("busy_second_frame", 32'(busy_a), 32'd1);
        send_frame(0, 8'($urandom), 1'($urandom_range(0, 1)), 0, 0, -1, 0, 0, 0);
        start_v[0] = 1'b0;
        repeat (4) tick();
        check("load_count_b2b", 32'(loads[0] - l0), 32'd2);

        // Randomized frames with bubbles and stray start pulses on both instances.
        for (int r = 0; r < 12; r++) begin
            for (int k = 0; k < 2; k++) begin
                send_frame(k, 8'($urandom), 1'($urandom_range(0, 1)), 1, 0, -1, 0, 1, 1);
                repeat ($urandom_range(1, 3)) tick();
            end
        end

        // Any expectation still queued means a load never arrived.
        repeat (5) tick();
        check("pending_a", 32'(q0.size()), 32'd0);
        check("pending_b", 32'(q1.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
